// File: rtl/phase_sequencer.sv
// Variable-latency instruction phase controller: steps fetch/decode/execute,
// waits on divider and memory handshakes with a timeout, then writes back.
module phase_sequencer #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_div,
  input  logic       is_mem,
  input  logic       div_done,
  input  logic       mem_ready,
  output logic       stall,
  output logic       reg_write_stall,
  output logic       mem_stall,
  output logic       div_start,
  output logic [2:0] phase,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_DIV    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Held as a plain vector so the illegal encodings 6 and 7 stay representable.
  logic [2:0]       state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             mem_q, mem_d;
  logic             terr_q, terr_d;

  // State, wait counter, decoded instruction class and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      mem_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mem_q   <= mem_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic and enable decode of the registered state.
  always_comb begin
    state_d         = S_FETCH;
    cnt_d           = cnt_q;
    div_d           = div_q;
    mem_d           = mem_q;
    terr_d          = terr_q;
    stall           = 1'b1;
    reg_write_stall = 1'b1;
    mem_stall       = 1'b1;
    div_start       = 1'b0;

    case (state_q)
      S_FETCH: begin
        stall   = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        div_d   = is_div;
        mem_d   = is_mem & ~is_div;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = '0;
        if (div_q)      state_d = S_DIV;
        else if (mem_q) state_d = S_MEM;
        else            state_d = S_WB;
      end
      S_DIV: begin
        div_start = (cnt_q == '0);
        // A done seen on the launch cycle belongs to a previous operation.
        if ((cnt_q != '0) && div_done) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_DIV;
        end
      end
      S_MEM: begin
        mem_stall = 1'b0;
        if (mem_ready) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write_stall = 1'b0;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      stall           = 1'b1;
      reg_write_stall = 1'b1;
      mem_stall       = 1'b1;
      div_start       = 1'b0;
    end
  end

  assign phase       = rst ? 3'd0 : state_q;
  assign timeout_err = terr_q & ~rst;

endmodule

// File: tb/tb_phase_sequencer.sv
// Cycle-by-cycle scoreboard bench for phase_sequencer with TIMEOUT=8.
module tb_phase_sequencer;

  localparam int unsigned TO = 8;
  localparam logic [7:0] RST_V = 8'h38;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       is_div = 1'b0;
  logic       is_mem = 1'b0;
  logic       div_done = 1'b0;
  logic       mem_ready = 1'b0;
  logic       stall, reg_write_stall, mem_stall, div_start, timeout_err;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  logic te = 1'b0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  phase_sequencer #(.TIMEOUT(TO), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .is_div(is_div), .is_mem(is_mem),
    .div_done(div_done), .mem_ready(mem_ready), .stall(stall),
    .reg_write_stall(reg_write_stall), .mem_stall(mem_stall),
    .div_start(div_start), .phase(phase), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed {te,ds,ms,rws,st,ph}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Expected output vector {timeout_err, div_start, mem_stall, reg_write_stall, stall, phase}.
  function automatic logic [7:0] expv(input logic [2:0] ph, input logic ds, input logic t);
    return {t, ds, ph != 3'd4, ph != 3'd5, ph != 3'd0, ph};
  endfunction

  task automatic drive(input string tag, input logic r, input logic d, input logic m,
                       input logic dd, input logic mr, input logic [7:0] exp);
    rst = r; is_div = d; is_mem = m; div_done = dd; mem_ready = mr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    #1;
    check(tag_q.pop_front(),
          {timeout_err, div_start, mem_stall, reg_write_stall, stall, phase},
          exp_q.pop_front());
  endtask

  task automatic cyc(input string tag, input logic r, input logic d, input logic m,
                     input logic dd, input logic mr, input logic [7:0] exp);
    drive(tag, r, d, m, dd, mr, exp);
    compare_out();
    @(negedge clk);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // One instruction: n wait cycles; finish=0 lets the wait time out.
  task automatic instr(input string tag, input logic d, input logic m, input int n,
                       input logic finish);
    logic [2:0] ws;
    ws = d ? 3'd3 : 3'd4;
    cyc({tag, "_f"}, 1'b0, rnd(), rnd(), rnd(), rnd(), expv(3'd0, 1'b0, te));
    cyc({tag, "_d"}, 1'b0, d, m, rnd(), rnd(), expv(3'd1, 1'b0, te));
    cyc({tag, "_e"}, 1'b0, rnd(), rnd(), rnd(), rnd(), expv(3'd2, 1'b0, te));
    for (int k = 0; k < n; k++) begin
      logic last;
      last = (k == n - 1) && finish;
      if (ws == 3'd3)
        cyc($sformatf("%s_div%0d", tag, k), 1'b0, rnd(), rnd(), (k == 0) || last, rnd(),
            expv(ws, k == 0, te));
      else
        cyc($sformatf("%s_mem%0d", tag, k), 1'b0, rnd(), rnd(), rnd(), last,
            expv(ws, 1'b0, te));
    end
    if (n == 0 || finish)
      cyc({tag, "_wb"}, 1'b0, rnd(), rnd(), rnd(), rnd(), expv(3'd5, 1'b0, te));
    else
      te = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    cyc("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RST_V);
    cyc("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RST_V);

    instr("alu0", 1'b0, 1'b0, 0, 1'b1);
    instr("alu1", 1'b0, 1'b0, 0, 1'b1);
    instr("load3", 1'b0, 1'b1, 3, 1'b1);
    instr("load1", 1'b0, 1'b1, 1, 1'b1);
    instr("div6", 1'b1, 1'b0, 6, 1'b1);
    instr("both", 1'b1, 1'b1, 2, 1'b1);
    instr("divto", 1'b1, 1'b0, TO, 1'b0);
    instr("alu_after_to", 1'b0, 1'b0, 0, 1'b1);
    instr("memto", 1'b0, 1'b1, TO, 1'b0);
    instr("alu2", 1'b0, 1'b0, 0, 1'b1);

    // Illegal encoding must fall back to fetch on the next edge.
    cyc("ill_f", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd0, 1'b0, te));
    force dut.state_q = 3'd7;
    drive("ill_7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd7, 1'b0, te));
    compare_out();
    release dut.state_q;
    @(negedge clk);
    instr("alu_after_ill", 1'b0, 1'b0, 0, 1'b1);

    // Reset during the third memory wait cycle clears the sticky flag.
    cyc("rm_f", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd0, 1'b0, te));
    cyc("rm_d", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, expv(3'd1, 1'b0, te));
    cyc("rm_e", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd2, 1'b0, te));
    cyc("rm_m0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd4, 1'b0, te));
    cyc("rm_m1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd4, 1'b0, te));
    cyc("rm_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RST_V);
    cyc("rm_rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RST_V);
    te = 1'b0;
    instr("alu_after_rst", 1'b0, 1'b0, 0, 1'b1);

    // Reset on the divider launch cycle suppresses div_start.
    cyc("rd_f", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd0, 1'b0, te));
    cyc("rd_d", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, expv(3'd1, 1'b0, te));
    cyc("rd_e", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expv(3'd2, 1'b0, te));
    cyc("rd_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RST_V);
    instr("alu_after_rd", 1'b0, 1'b0, 0, 1'b1);
    instr("div2", 1'b1, 1'b0, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
